// File: rtl/spi_flash_responder_if.sv
`timescale 1ns/1ps
// Pin-level SPI flash bus plus the byte-wide backing-memory read port.
// The responder takes the slave modport; the SoC/bench side takes master.
interface spi_flash_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  flash_csb;
  logic                  flash_clk;
  logic                  flash_io0;
  logic                  flash_io1_do;
  logic                  flash_io1_oeb;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_rdata;

  modport master (
    output flash_csb, flash_clk, flash_io0, mem_rdata,
    input  flash_io1_do, flash_io1_oeb, mem_addr, mem_rd
  );

  modport slave (
    input  flash_csb, flash_clk, flash_io0, mem_rdata,
    output flash_io1_do, flash_io1_oeb, mem_addr, mem_rd
  );
endinterface

// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// Mode-0 single-bit SPI flash emulator, oversampled on the system clock, serving reads from external memory.
// Define SPI_FLASH_FAST_READ_EN to accept 0x0B (fast read with 8 dummy clocks).
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                 clock,
  input  logic                 resetb,
  spi_flash_responder_if.slave bus,
  output logic [7:0]           last_cmd,
  output logic                 bad_cmd
);

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_FAST_READ  = 8'h0B;
  localparam logic [7:0] CMD_JEDEC_ID   = 8'h9F;
  localparam logic [7:0] CMD_RELEASE    = 8'hAB;
  localparam logic [7:0] CMD_RESET_MODE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  state_t                state_r, state_n;
  logic                  csb_meta_r, csb_sync_r, csb_prev_r;
  logic                  clk_meta_r, clk_sync_r, clk_prev_r;
  logic                  io0_meta_r, io0_sync_r;
  logic [2:0]            bit_cnt_r, bit_cnt_n;
  logic [1:0]            byte_cnt_r, byte_cnt_n;
  logic [22:0]           shift_in_r, shift_in_n;
  logic [6:0]            out_sr_r, out_sr_n;
  logic [7:0]            prefetch_r;
  logic                  rd_pend_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_n;
  logic                  mem_rd_r, mem_rd_n;
  logic                  do_r, do_n;
  logic                  oeb_r, oeb_n;
  logic [7:0]            last_cmd_r, last_cmd_n;
  logic                  bad_cmd_r, bad_cmd_n;

  logic                  rise_s, fall_s, select_s;
  logic [7:0]            cmd_byte_s;
  logic [23:0]           addr_word_s;
  logic [7:0]            load_byte_s;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
  endfunction

  // Input synchronisers; csb resets low so a select already in progress at reset release is not seen as new
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      csb_meta_r <= 1'b0;
      csb_sync_r <= 1'b0;
      csb_prev_r <= 1'b0;
      clk_meta_r <= 1'b0;
      clk_sync_r <= 1'b0;
      clk_prev_r <= 1'b0;
      io0_meta_r <= 1'b0;
      io0_sync_r <= 1'b0;
    end else begin
      csb_meta_r <= bus.flash_csb;
      csb_sync_r <= csb_meta_r;
      csb_prev_r <= csb_sync_r;
      clk_meta_r <= bus.flash_clk;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      io0_meta_r <= bus.flash_io0;
      io0_sync_r <= io0_meta_r;
    end
  end

  assign rise_s      = clk_sync_r & ~clk_prev_r;
  assign fall_s      = ~clk_sync_r & clk_prev_r;
  assign select_s    = csb_prev_r & ~csb_sync_r;
  assign cmd_byte_s  = {shift_in_r[6:0], io0_sync_r};
  assign addr_word_s = {shift_in_r, io0_sync_r};
  assign load_byte_s = (state_r == ST_DATA) ? prefetch_r : id_byte(byte_cnt_r);

  generate
    if (ADDR_WIDTH < 24) begin : g_addr_trunc
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^addr_word_s[23:ADDR_WIDTH];
    end
  endgenerate

  // Capture memory data the cycle after each strobe and hold it until the next byte load
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rd_pend_r  <= 1'b0;
      prefetch_r <= 8'h00;
    end else begin
      rd_pend_r <= mem_rd_r;
      if (rd_pend_r) begin
        prefetch_r <= bus.mem_rdata;
      end
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      shift_in_r <= 23'd0;
      out_sr_r   <= 7'd0;
      mem_addr_r <= {ADDR_WIDTH{1'b0}};
      mem_rd_r   <= 1'b0;
      do_r       <= 1'b0;
      oeb_r      <= 1'b1;
      last_cmd_r <= 8'h00;
      bad_cmd_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      byte_cnt_r <= byte_cnt_n;
      shift_in_r <= shift_in_n;
      out_sr_r   <= out_sr_n;
      mem_addr_r <= mem_addr_n;
      mem_rd_r   <= mem_rd_n;
      do_r       <= do_n;
      oeb_r      <= oeb_n;
      last_cmd_r <= last_cmd_n;
      bad_cmd_r  <= bad_cmd_n;
    end
  end

  // Next-state and output decode; deselect overrides any edge seen in the same cycle
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    byte_cnt_n = byte_cnt_r;
    shift_in_n = shift_in_r;
    out_sr_n   = out_sr_r;
    mem_addr_n = mem_addr_r;
    mem_rd_n   = 1'b0;
    do_n       = do_r;
    oeb_n      = oeb_r;
    last_cmd_n = last_cmd_r;
    bad_cmd_n  = 1'b0;
    if (csb_sync_r) begin
      state_n    = ST_IDLE;
      bit_cnt_n  = 3'd0;
      byte_cnt_n = 2'd0;
      oeb_n      = 1'b1;
      do_n       = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          oeb_n = 1'b1;
          if (select_s) begin
            state_n    = ST_CMD;
            bit_cnt_n  = 3'd0;
            byte_cnt_n = 2'd0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (rise_s) begin
            shift_in_n = {shift_in_r[21:0], io0_sync_r};
            bit_cnt_n  = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              last_cmd_n = cmd_byte_s;
              case (cmd_byte_s)
                CMD_READ:     state_n = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                CMD_FAST_READ: state_n = ST_ADDR;
`endif
                CMD_JEDEC_ID: state_n = ST_ID;
                CMD_RELEASE, CMD_RESET_MODE: state_n = ST_IGNORE;
                default: begin
                  state_n   = ST_IGNORE;
                  bad_cmd_n = 1'b1;
                end
              endcase
            end else begin
              state_n = ST_CMD;
            end
          end else begin
            state_n = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            shift_in_n = {shift_in_r[21:0], io0_sync_r};
            bit_cnt_n  = bit_cnt_r + 3'd1;
            if ((bit_cnt_r == 3'd7) && (byte_cnt_r == 2'd2)) begin
              byte_cnt_n = 2'd0;
              mem_addr_n = addr_word_s[ADDR_WIDTH-1:0];
`ifdef SPI_FLASH_FAST_READ_EN
              if (last_cmd_r == CMD_FAST_READ) begin
                state_n = ST_DUMMY;
              end else begin
                state_n  = ST_DATA;
                mem_rd_n = 1'b1;
              end
`else
              state_n  = ST_DATA;
              mem_rd_n = 1'b1;
`endif
            end else if (bit_cnt_r == 3'd7) begin
              byte_cnt_n = byte_cnt_r + 2'd1;
            end else begin
              byte_cnt_n = byte_cnt_r;
            end
          end else begin
            state_n = ST_ADDR;
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          oeb_n = 1'b1;
          if (rise_s && (bit_cnt_r == 3'd7)) begin
            bit_cnt_n = 3'd0;
            mem_rd_n  = 1'b1;
            state_n   = ST_DATA;
          end else if (rise_s) begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end else begin
            state_n = ST_DUMMY;
          end
        end
`endif
        ST_DATA, ST_ID: begin
          if (fall_s) begin
            bit_cnt_n = bit_cnt_r + 3'd1;
            oeb_n     = 1'b0;
            if (bit_cnt_r == 3'd0) begin
              out_sr_n = load_byte_s[6:0];
              do_n     = load_byte_s[7];
              // Prefetch the next byte a full byte-time ahead of when it is shifted out
              if (state_r == ST_DATA) begin
                mem_addr_n = mem_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                mem_rd_n   = 1'b1;
              end else begin
                byte_cnt_n = (byte_cnt_r == 2'd3) ? 2'd3 : (byte_cnt_r + 2'd1);
              end
            end else begin
              out_sr_n = {out_sr_r[5:0], 1'b0};
              do_n     = out_sr_r[6];
            end
          end else begin
            oeb_n = oeb_r;
          end
        end
        ST_IGNORE: begin
          oeb_n   = 1'b1;
          state_n = ST_IGNORE;
        end
        default: begin
          oeb_n   = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.flash_io1_do  = do_r;
  assign bus.flash_io1_oeb = oeb_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_rd        = mem_rd_r;
  assign last_cmd          = last_cmd_r;
  assign bad_cmd           = bad_cmd_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_flash_responder: directed SPI transactions at a 10x clock ratio,
// expected MISO bytes queued at issue time and checked by an independent SPI-master monitor.
module tb_spi_flash_responder;
  logic       clock = 1'b0;
  logic       resetb;
  logic [7:0] last_cmd;
  logic       bad_cmd;
  logic [7:0] mem [0:65535];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int bad_cycles = 0;
  int oeb_low_cnt = 0;

  spi_flash_responder_if #(.ADDR_WIDTH(16)) bus ();

  spi_flash_responder #(.ADDR_WIDTH(16), .JEDEC_ID(24'hEF4016)) dut (
    .clock   (clock),
    .resetb  (resetb),
    .bus     (bus),
    .last_cmd(last_cmd),
    .bad_cmd (bad_cmd)
  );

  always #5 clock = ~clock;

  // Backing memory: data valid the cycle after the strobe
  always @(posedge clock) if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];

  always @(negedge clock) begin
    if (bus.mem_rd === 1'b1) rd_cnt++;
    if (bad_cmd === 1'b1) bad_cycles++;
    if (bus.flash_io1_oeb === 1'b0) oeb_low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: behaves like the SoC master, sampling MISO on each flash_clk rise while driven
  initial begin
    int         mon_cnt;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    mon_cnt  = 0;
    mon_byte = 8'h00;
    forever begin
      @(posedge bus.flash_clk or posedge bus.flash_csb);
      if (bus.flash_csb === 1'b1) begin
        mon_cnt = 0;
      end else if (bus.flash_io1_oeb === 1'b0) begin
        mon_byte = {mon_byte[6:0], bus.flash_io1_do};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got %02h with no byte expected", mon_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("miso_byte", {24'd0, mon_byte}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b);
    bus.flash_io0 = b;
    repeat (5) @(negedge clock);
    bus.flash_clk = 1'b1;
    repeat (5) @(negedge clock);
    bus.flash_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    @(negedge clock);
    bus.flash_csb = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Raised in the same step as the last clock fall, so deselect must win over that edge
  task automatic cs_high();
    bus.flash_csb = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic read_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes, input logic dummy);
    cs_low();
    spi_byte(cmd);
    spi_byte(addr[23:16]);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    if (dummy) spi_byte(8'h00);
    for (int i = 0; i < nbytes; i++) spi_byte(8'h00);
    cs_high();
  endtask

  initial begin
    int rst_viol;
    int rd0, bad0, oeb0;
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ 8'h5A;
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h3C;
    mem[16'hFFFF] = 8'h77;
    mem[16'h0000] = 8'h88;

    // 1. reset held while pins toggle
    resetb = 1'b0;
    bus.flash_csb = 1'b1;
    bus.flash_clk = 1'b0;
    bus.flash_io0 = 1'b0;
    rst_viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.flash_clk = i[0];
      bus.flash_io0 = i[1];
      bus.flash_csb = i[2];
      if (bus.flash_io1_oeb !== 1'b1 || bus.mem_rd !== 1'b0 || last_cmd !== 8'h00) rst_viol++;
    end
    check("reset_hold_violations", rst_viol, 32'd0);
    check("reset_do", {31'd0, bus.flash_io1_do}, 32'd0);
    check("reset_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("reset_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    bus.flash_csb = 1'b1;
    bus.flash_clk = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (6) @(negedge clock);

    // 2. basic read of two bytes at 0x0100
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    rd0 = rd_cnt;
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h01);
    spi_byte(8'h00);
    check("read_rd_after_addr", rd_cnt - rd0, 32'd1);
    check("read_addr_after_addr", {16'd0, bus.mem_addr}, 32'h0100);
    spi_byte(8'h00);
    spi_byte(8'h00);
    cs_high();
    check("read_last_cmd", {24'd0, last_cmd}, 32'h03);
    check("read_rd_total", rd_cnt - rd0, 32'd3);
    check("read_addr_end", {16'd0, bus.mem_addr}, 32'h0102);

    // 3. wrap at top of memory; upper address byte truncated
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h88);
    read_txn(8'h03, 24'h12FFFF, 2, 1'b0);
    check("wrap_addr_end", {16'd0, bus.mem_addr}, 32'h0001);

    // 4. JEDEC ID followed by idle-high
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    exp_q.push_back(8'hFF);
    cs_low();
    spi_byte(8'h9F);
    for (int i = 0; i < 4; i++) spi_byte(8'h00);
    cs_high();
    check("id_last_cmd", {24'd0, last_cmd}, 32'h9F);

    // 5. unsupported command, then a tolerated one, then a normal read
    bad0 = bad_cycles;
    oeb0 = oeb_low_cnt;
    cs_low();
    spi_byte(8'h5A);
    spi_byte(8'h00);
    cs_high();
    check("bad_cmd_pulse_cycles", bad_cycles - bad0, 32'd1);
    check("bad_cmd_oeb_low", oeb_low_cnt - oeb0, 32'd0);
    check("bad_last_cmd", {24'd0, last_cmd}, 32'h5A);
    bad0 = bad_cycles;
    oeb0 = oeb_low_cnt;
    cs_low();
    spi_byte(8'hAB);
    spi_byte(8'h00);
    cs_high();
    check("ab_no_bad_cmd", bad_cycles - bad0, 32'd0);
    check("ab_oeb_low", oeb_low_cnt - oeb0, 32'd0);
    exp_q.push_back(8'hA5);
    read_txn(8'h03, 24'h000100, 1, 1'b0);
    check("after_bad_last_cmd", {24'd0, last_cmd}, 32'h03);

    // Fast read: accepted only when the feature is built in
    bad0 = bad_cycles;
    oeb0 = oeb_low_cnt;
`ifdef SPI_FLASH_FAST_READ_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    rd0 = rd_cnt;
    cs_low();
    spi_byte(8'h0B);
    spi_byte(8'h00);
    spi_byte(8'h01);
    spi_byte(8'h00);
    check("fast_no_rd_after_addr", rd_cnt - rd0, 32'd0);
    spi_byte(8'h00);
    check("fast_rd_after_dummy", rd_cnt - rd0, 32'd1);
    check("fast_oeb_in_dummy", oeb_low_cnt - oeb0, 32'd0);
    spi_byte(8'h00);
    spi_byte(8'h00);
    cs_high();
    check("fast_no_bad_cmd", bad_cycles - bad0, 32'd0);
`else
    read_txn(8'h0B, 24'h000100, 2, 1'b1);
    check("fast_bad_cmd", bad_cycles - bad0, 32'd1);
    check("fast_oeb_low", oeb_low_cnt - oeb0, 32'd0);
`endif
    check("fast_last_cmd", {24'd0, last_cmd}, 32'h0B);

    // 6. abort after 12 address bits, then a full read
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    bus.flash_csb = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_oeb", {31'd0, bus.flash_io1_oeb}, 32'd1);
    repeat (5) @(negedge clock);
    exp_q.push_back(8'h3C);
    read_txn(8'h03, 24'h000101, 1, 1'b0);

    // Partial command byte must not update last_cmd
    bad0 = bad_cycles;
    cs_low();
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b0);
    spi_bit(1'b1);
    cs_high();
    check("short_cmd_last_cmd", {24'd0, last_cmd}, 32'h03);
    check("short_cmd_bad", bad_cycles - bad0, 32'd0);

    // Reset mid-read: outputs clear at once, no response until a fresh select
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h01);
    spi_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    @(negedge clock);
    resetb = 1'b0;
    #1;
    check("midrst_oeb", {31'd0, bus.flash_io1_oeb}, 32'd1);
    check("midrst_do", {31'd0, bus.flash_io1_do}, 32'd0);
    check("midrst_last_cmd", {24'd0, last_cmd}, 32'h00);
    check("midrst_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    oeb0 = oeb_low_cnt;
    spi_byte(8'h9F);
    spi_byte(8'h00);
    spi_byte(8'h00);
    check("midrst_no_response", oeb_low_cnt - oeb0, 32'd0);
    check("midrst_no_cmd", {24'd0, last_cmd}, 32'h00);
    cs_high();
    exp_q.push_back(8'h3C);
    read_txn(8'h03, 24'h000101, 1, 1'b0);

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI-flash emulator for FPGA validation. It is the far-end responder to the management SoC's flash interface (flash_csb, flash_clk, flash_io0, flash_io1), so firmware can boot from FPGA block RAM instead of a physical flash part. SPI mode 0 only, single-bit I/O. All SPI pins are oversampled on the system clock; no logic runs on flash_clk.

Parameters:
ADDR_WIDTH, 16, byte-address width of the backing memory; the 24-bit SPI address is truncated to its low ADDR_WIDTH bits.
JEDEC_ID, 24'hEF4016, 3-byte ID returned MSB first for command 0x9F.

Ports:
clock  input  1  system clock; must be at least 8x the flash_clk frequency
resetb  input  1  asynchronous active-low reset
flash_csb  input  1  chip select from the SoC, active low
flash_clk  input  1  SPI clock from the SoC
flash_io0  input  1  MOSI
flash_io1_do  output  1  MISO data toward the pad buffer
flash_io1_oeb  output  1  MISO output enable, active low (1 = hi-Z)
mem_addr  output  ADDR_WIDTH  backing-memory byte address
mem_rd  output  1  one-cycle read strobe
mem_rdata  input  8  read data, valid on the cycle after mem_rd
last_cmd  output  8  most recent command byte received
bad_cmd  output  1  one-cycle pulse when an unsupported command byte completes

Behaviour:
- Reset values: flash_io1_do=0, flash_io1_oeb=1, mem_addr=0, mem_rd=0, last_cmd=0, bad_cmd=0, state=IDLE.
- Synchronisation: flash_csb, flash_clk and flash_io0 each pass through a 2-flop synchroniser. A third flop on flash_clk produces rise and fall pulses.
- Sampling: MOSI is sampled on the synchronised rising edge, MSB first. MISO is updated on the synchronised falling edge.
- Deselect: csb_sync=1 forces IDLE from any state, flash_io1_oeb=1, and clears the bit counter. This takes priority over any simultaneous edge.
- Entry to CMD occurs on the csb_sync 1->0 transition. The bit counter is 3 bits for bytes plus a byte counter.
- States:
  IDLE: oeb=1. Goes to CMD on select.
  CMD: shift in 8 bits. On the 8th rise, latch last_cmd, then branch: 0x03 -> ADDR; 0x9F -> ID; 0xAB or 0xFF -> IGNORE without error; anything else -> IGNORE and pulse bad_cmd.
  ADDR: shift in 24 bits. On the 24th rise, set mem_addr = addr[ADDR_WIDTH-1:0], pulse mem_rd, and go to DATA.
  DATA: on the first falling edge, load the shift register from mem_rdata, drive oeb=0 and flash_io1_do=bit7. On each later fall, shift out the next bit. On the fall that loads bit7 of a byte, increment mem_addr (wrapping modulo 2^ADDR_WIDTH) and pulse mem_rd to prefetch the next byte. Reads continue indefinitely until deselect.
  ID: same shift mechanism using the JEDEC_ID bytes. After 3 bytes, flash_io1_do=1 with oeb=0 until deselect.
  IGNORE: oeb=1, counts nothing, waits for deselect.
- Latency: MISO changes within 4 clock cycles of a flash_clk falling edge, which satisfies the master's next rising-edge sample at an 8x clock ratio.
- Timing limit: a clock ratio below 8x is outside the specification and carries no guarantee.
- Reset mid-transaction: all outputs return to their reset values immediately. Normal operation resumes on the next csb falling edge seen after resetb rises.
- Short transfer: a deselect partway through a byte discards the partial byte. last_cmd updates only on a complete command byte.

Optional Feature:
SPI_FLASH_FAST_READ_EN:
- Defined: command 0x0B is accepted. The flow is ADDR (24 bits), then DUMMY (8 rising edges, oeb=1), then DATA, identical to 0x03. mem_rd is pulsed at the end of DUMMY rather than the end of ADDR.
- Undefined: 0x0B is an unsupported command and goes to IGNORE with a bad_cmd pulse.

Test Plan:
1. Reset with resetb=0 while stimulus toggles -> flash_io1_oeb=1, mem_rd=0, last_cmd=0 throughout.
2. Memory preloaded 0x0100=0xA5, 0x0101=0x3C; send 0x03 00 01 00 then clock 16 bits at 10x ratio -> MISO bytes 0xA5, 0x3C; last_cmd=0x03; mem_rd pulses at the end of ADDR and at the start of byte 1.
3. Read at address 0xFFFF with ADDR_WIDTH=16 for 2 bytes -> returns mem[0xFFFF] then mem[0x0000].
4. Send 0x9F and clock 32 bits -> 0xEF, 0x40, 0x16, 0xFF.
5. Send 0x5A -> bad_cmd pulses exactly one cycle; oeb stays 1; a following 0x03 transaction after deselect reads correctly.
6. Raise csb after 12 address bits, then issue a full 0x03 read -> first transaction is aborted with oeb=1 within 3 cycles; second returns correct data. With SPI_FLASH_FAST_READ_EN defined, 0x0B plus 8 dummy clocks returns the same data.
